// File: rtl/axi_err_resp.sv
// -----------------------------------------------------------------------------
// axi_err_resp
//   Terminating AXI4 subordinate. Accepts every AW/W/AR transfer and answers
//   with B and R responses carrying RespCode, never touching memory. Read
//   bursts are answered with the full len+1 beats.
//
// Ports
//   clk_i       in   1       clock, rising edge
//   rst_i       in   1       synchronous active-high reset
//   slv_req_i   in   req_t   AXI4 request struct from the upstream manager
//   slv_resp_o  out  resp_t  AXI4 response struct to the upstream manager
//
// Build option
//   AXI_ERR_RESP_DATA_EN  defined   -> r.data repeats 32'hBADC_AB1E
//                         undefined -> r.data = '0
//
// The package supplies default request/response structs so the module
// elaborates stand-alone; integrators override req_t/resp_t.
// -----------------------------------------------------------------------------

package axi_err_resp_pkg;
    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefIdWidth   = 4;
    localparam int unsigned DefUserWidth = 1;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic [DefUserWidth-1:0] user;
    } ax_t;

    typedef struct packed {
        logic [DefDataWidth-1:0]   data;
        logic [DefDataWidth/8-1:0] strb;
        logic                      last;
        logic [DefUserWidth-1:0]   user;
    } w_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [DefUserWidth-1:0] user;
    } b_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [DefUserWidth-1:0] user;
    } r_t;

    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;

    typedef struct packed {
        logic aw_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        logic ar_ready;
        r_t   r;
        logic r_valid;
    } resp_t;
endpackage

// -----------------------------------------------------------------------------
// axi_err_resp_fifo
//   Small synchronous FIFO. full_o/empty_o derive only from the registered
//   occupancy count, so there is no push-through path when full.
//   Ports: push_i/data_i write side, pop_i/data_o read side (data_o = head).
// -----------------------------------------------------------------------------
module axi_err_resp_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [Width-1:0]    mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                do_push, do_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        if (p == PtrWidth'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Guards make the FIFO self-protecting even though the wrapper never
    // pushes when full or pops when empty.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end
endmodule

// -----------------------------------------------------------------------------
// axi_err_resp (top)
//   Read FSM states:
//     state    | meaning
//     R_IDLE   | no burst active; pops the next AR {id,len} when one is queued
//     R_BURST  | presenting error beats; r.last when the remaining count is 0
// -----------------------------------------------------------------------------
module axi_err_resp #(
    parameter type         req_t     = axi_err_resp_pkg::req_t,
    parameter type         resp_t    = axi_err_resp_pkg::resp_t,
    parameter int unsigned AddrWidth = 32'd32,
    parameter int unsigned DataWidth = 32'd64,
    parameter int unsigned IdWidth   = 32'd4,
    parameter int unsigned UserWidth = 32'd1,
    parameter logic [1:0]  RespCode  = 2'b11,
    parameter int unsigned MaxTxns   = 32'd4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o
);
    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_e;

    // Address and user widths only shape the structs; nothing here needs them.
    localparam int unsigned unused_widths = AddrWidth + UserWidth + DataWidth;

    logic                  unused_req;
    logic                  init_q, init_d;

    logic                  aw_ready, aw_full, aw_empty;
    logic [IdWidth-1:0]    aw_head;
    logic                  w_ready, w_last_fire;
    logic                  b_valid, b_full, b_empty, b_pop;
    logic [IdWidth-1:0]    b_head;
    logic                  ar_ready, ar_full, ar_empty, ar_pop;
    logic [IdWidth+7:0]    ar_head;

    r_state_e              state_q, state_d;
    logic [IdWidth-1:0]    r_id_q, r_id_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic                  r_valid, r_last;
    logic [DataWidth-1:0]  r_data;

    // Most request fields are intentionally ignored.
    assign unused_req = ^slv_req_i;

    // Holds every ready low for the cycle after reset is sampled and while
    // it stays asserted; the FIFOs alone would report "not full" then.
    always_comb init_d = rst_i;

    always_ff @(posedge clk_i) begin
        init_q <= init_d;
    end

    // ---------------- write path ----------------
    assign aw_ready    = !init_q && !aw_full;
    assign w_ready     = !init_q && !aw_empty && (!b_full || !slv_req_i.w.last);
    assign w_last_fire = slv_req_i.w_valid && w_ready && slv_req_i.w.last;
    assign b_valid     = !b_empty;
    assign b_pop       = b_valid && slv_req_i.b_ready;

    axi_err_resp_fifo #(
        .Width (IdWidth),
        .Depth (MaxTxns)
    ) i_aw_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (slv_req_i.aw_valid && aw_ready),
        .data_i  (slv_req_i.aw.id),
        .pop_i   (w_last_fire),
        .data_o  (aw_head),
        .full_o  (aw_full),
        .empty_o (aw_empty)
    );

    axi_err_resp_fifo #(
        .Width (IdWidth),
        .Depth (MaxTxns)
    ) i_b_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_last_fire),
        .data_i  (aw_head),
        .pop_i   (b_pop),
        .data_o  (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    // ---------------- read path ----------------
    assign ar_ready = !init_q && !ar_full;

    axi_err_resp_fifo #(
        .Width (IdWidth + 8),
        .Depth (MaxTxns)
    ) i_ar_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (slv_req_i.ar_valid && ar_ready),
        .data_i  ({slv_req_i.ar.id, slv_req_i.ar.len}),
        .pop_i   (ar_pop),
        .data_o  (ar_head),
        .full_o  (ar_full),
        .empty_o (ar_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
            r_id_q  <= '0;
            r_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            r_id_q  <= r_id_d;
            r_cnt_q <= r_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_id_d  = r_id_q;
        r_cnt_d = r_cnt_q;
        ar_pop  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!ar_empty) begin
                    ar_pop  = 1'b1;
                    r_id_d  = ar_head[IdWidth+7:8];
                    r_cnt_d = ar_head[7:0];
                    state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (slv_req_i.r_ready) begin
                    if (r_cnt_q == 8'd0) begin
                        state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_comb begin
        r_valid = (state_q == R_BURST);
        r_last  = (state_q == R_BURST) && (r_cnt_q == 8'd0);
    end

`ifdef AXI_ERR_RESP_DATA_EN
    localparam logic [31:0] DataPattern = 32'hBADC_AB1E;

    always_comb begin
        r_data = '0;
        for (int i = 0; i < int'(DataWidth); i++) begin
            r_data[i] = DataPattern[i % 32];
        end
    end
`else
    assign r_data = '0;
`endif

    // ---------------- response assembly ----------------
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.b.id     = b_head;
        slv_resp_o.b.resp   = RespCode;
        slv_resp_o.b_valid  = b_valid;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.r.id     = r_id_q;
        slv_resp_o.r.data   = r_data;
        slv_resp_o.r.resp   = RespCode;
        slv_resp_o.r.last   = r_last;
        slv_resp_o.r_valid  = r_valid;
    end
endmodule
